register_bank_mp: RTL
=====================

// Module: register_bank_mp
// PURPOSE
//  Multi-read-port integer register file: successor of the 2R1W bank. Adds N read ports,
//  same-cycle write-to-read bypass, a busy scoreboard for in-flight writebacks, and a
//  post-reset hardware clear sequence with a ready flag. Sits between decode/issue and writeback.
// PARAMETERS
//  BANK_WIDTH      5   register index width; SIZE = 2**BANK_WIDTH entries
//  REGISTER_WIDTH  32  data width of each register
//  READ_PORTS      2   number of independent read ports (>=1)
//  BYPASS          1   1: forward rd_data to same-cycle reads/busy of rd_sel; 0: no forwarding
// PORTS
//  clk        in   1                          clock; all state updates on posedge
//  rst        in   1                          synchronous reset, active-low
//  rs_sel     in   READ_PORTS*BANK_WIDTH      packed read indices; port i = [i*BW +: BW]
//  rs_data    out  READ_PORTS*REGISTER_WIDTH  packed read data, combinational from rs_sel
//  rs_busy    out  READ_PORTS                 1: register on port i has a pending writeback
//  reg_w      in   1                          writeback strobe
//  rd_sel     in   BANK_WIDTH                 writeback index
//  rd_data    in   REGISTER_WIDTH             writeback data
//  alloc_v    in   1                          issue: mark alloc_sel busy
//  alloc_sel  in   BANK_WIDTH                 index to mark busy
//  ready      out  1                          1: clear done, bank accepts reg_w/alloc_v
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state<=CLEAR, clr_cnt<=0, all busy bits<=0, ready<=0. Takes
//    effect at any time, incl. mid-clear (restart from 0) or mid-operation (pending busy lost).
//  - CLEAR (rst==1): each posedge writes mem[clr_cnt]<=0, clr_cnt++; on clr_cnt==SIZE-1 write
//    then state<=RUN, ready<=1. ready rises exactly SIZE posedges after rst deasserts.
//    In CLEAR: reg_w, alloc_v ignored; rs_data all 0; rs_busy all 0.
//  - RUN: reg_w && rd_sel!=0 -> mem[rd_sel]<=rd_data, busy[rd_sel]<=0 at posedge.
//    alloc_v && alloc_sel!=0 -> busy[alloc_sel]<=1. Same index both: alloc wins (busy stays 1,
//    data still written) -- a newer producer supersedes.
//  - Register 0: never written, never busy; rs_data=0, rs_busy=0 for any port selecting 0.
//  - Reads: zero-latency combinational. Port i: sel==0 -> 0; else if BYPASS && reg_w && ready
//    && rd_sel==sel -> rd_data with rs_busy=0; else mem[sel], rs_busy=busy[sel].
//  - Ports independent: any number may select the same index in one cycle.
//  - Index arithmetic wraps modulo SIZE; clr_cnt is BANK_WIDTH bits, never overflows into RUN.
//  - ready is registered; held 1 in RUN until next reset.
// STRUCTURE
//  - Shared header rf_defs.vh: state encodings RF_CLEAR=1'b0, RF_RUN=1'b1; default widths.
//  - Sub-module rf_scoreboard (SIZE-bit busy vector: set/clear/flush, READ_PORTS lookups).
//  - Top holds storage array, clear FSM/counter, bypass muxes (generate loop over ports).
// TESTING
//  1. rst=0 one cycle, then 1 -> ready=0 for 32 edges, 1 after 32nd; all 32 regs read 0.
//  2. RUN: reg_w rd_sel=5 rd_data=32'hDEADBEEF; same cycle rs_sel[0]=5 -> rs_data[0]=DEADBEEF
//     (BYPASS=1); next cycle still DEADBEEF from array; BYPASS=0 -> old value 0 same cycle.
//  3. alloc_v sel=7 -> next cycle rs_busy for 7 =1; reg_w rd_sel=7 -> busy 0 next cycle,
//     bypass shows busy 0 in the writeback cycle.
//  4. Same cycle alloc_v sel=9 and reg_w rd_sel=9 data=1 -> mem[9]=1, busy[9]=1.
//  5. reg_w rd_sel=0 data=FFFF_FFFF, alloc_v sel=0 -> x0 reads 0, busy 0 on all ports.
//  6. Reset asserted at clr_cnt=10 -> clear restarts; ready after 32 more edges; writes
//     during CLEAR ignored (reg 3 written mid-clear reads 0 after ready).

Source files
------------

// File: rtl/register_bank_mp_pkg.sv
// Shared types and default widths for the multi-read-port register bank.
package register_bank_mp_pkg;

    localparam int unsigned DefBankWidth     = 5;
    localparam int unsigned DefRegisterWidth = 32;
    localparam int unsigned DefReadPorts     = 2;
    localparam int unsigned DefBypass        = 1;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/register_bank_mp_if.sv
// Issue/writeback/read bus of the register bank; the bank is the slave side.
interface register_bank_mp_if
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned BANK_WIDTH     = DefBankWidth,
    parameter int unsigned REGISTER_WIDTH = DefRegisterWidth,
    parameter int unsigned READ_PORTS     = DefReadPorts
) ();

    logic [READ_PORTS*BANK_WIDTH-1:0]     rs_sel;
    logic [READ_PORTS*REGISTER_WIDTH-1:0] rs_data;
    logic [READ_PORTS-1:0]                rs_busy;
    logic                                 reg_w;
    logic [BANK_WIDTH-1:0]                rd_sel;
    logic [REGISTER_WIDTH-1:0]            rd_data;
    logic                                 alloc_v;
    logic [BANK_WIDTH-1:0]                alloc_sel;
    logic                                 ready;

    modport master (
        output rs_sel, reg_w, rd_sel, rd_data, alloc_v, alloc_sel,
        input  rs_data, rs_busy, ready
    );

    modport slave (
        input  rs_sel, reg_w, rd_sel, rd_data, alloc_v, alloc_sel,
        output rs_data, rs_busy, ready
    );

endinterface

// File: rtl/register_bank_mp_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback, flushed while clearing.
module register_bank_mp_scoreboard #(
    parameter int unsigned BANK_WIDTH = 5,
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             set_en,
    input  logic [BANK_WIDTH-1:0]            set_idx,
    input  logic                             clr_en,
    input  logic [BANK_WIDTH-1:0]            clr_idx,
    input  logic [READ_PORTS*BANK_WIDTH-1:0] lookup_idx,
    output logic [READ_PORTS-1:0]            lookup_busy
);

    localparam int unsigned Size = 2 ** BANK_WIDTH;

    logic [Size-1:0] busy_q;

    // Set is applied after clear so a same-index alloc supersedes the writeback.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            busy_q <= '0;
        end else begin
            if (clr_en) busy_q[clr_idx] <= 1'b0;
            if (set_en) busy_q[set_idx] <= 1'b1;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_lookup
        assign lookup_busy[i] = busy_q[lookup_idx[i*BANK_WIDTH +: BANK_WIDTH]];
    end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-read-port register bank with write bypass, busy scoreboard and post-reset clear.
module register_bank_mp
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned BANK_WIDTH     = DefBankWidth,
    parameter int unsigned REGISTER_WIDTH = DefRegisterWidth,
    parameter int unsigned READ_PORTS     = DefReadPorts,
    parameter int unsigned BYPASS         = DefBypass
) (
    input logic               clk,
    input logic               rst,
    register_bank_mp_if.slave bus
);

    localparam int unsigned Size = 2 ** BANK_WIDTH;

    rf_state_e                            state_q;
    logic [BANK_WIDTH-1:0]                clr_cnt_q;
    logic                                 ready_q;
    logic [REGISTER_WIDTH-1:0]            mem_q [Size];
    logic                                 wr_en;
    logic                                 alloc_en;
    logic [READ_PORTS-1:0]                sb_busy;
    logic [READ_PORTS*REGISTER_WIDTH-1:0] rs_data;
    logic [READ_PORTS-1:0]                rs_busy;

    // ready_q is high exactly while in StRun, so it gates all run-time activity.
    assign wr_en    = ready_q && bus.reg_w && (bus.rd_sel != '0);
    assign alloc_en = ready_q && bus.alloc_v && (bus.alloc_sel != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: ready_q <= 1'b1;
                default: state_q <= StClear;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state_q == StClear) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (rst && wr_en) begin
            mem_q[bus.rd_sel] <= bus.rd_data;
        end
    end

    register_bank_mp_scoreboard #(
        .BANK_WIDTH (BANK_WIDTH),
        .READ_PORTS (READ_PORTS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .flush       (!ready_q),
        .set_en      (alloc_en),
        .set_idx     (bus.alloc_sel),
        .clr_en      (wr_en),
        .clr_idx     (bus.rd_sel),
        .lookup_idx  (bus.rs_sel),
        .lookup_busy (sb_busy)
    );

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
        logic [BANK_WIDTH-1:0]     sel;
        logic                      fwd;
        logic [REGISTER_WIDTH-1:0] data;
        logic                      busy;

        assign sel = bus.rs_sel[i*BANK_WIDTH +: BANK_WIDTH];
        assign fwd = (BYPASS != 0) && wr_en && (bus.rd_sel == sel);

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (ready_q && sel != '0) begin
                data = fwd ? bus.rd_data : mem_q[sel];
                busy = fwd ? 1'b0 : sb_busy[i];
            end
        end

        assign rs_data[i*REGISTER_WIDTH +: REGISTER_WIDTH] = data;
        assign rs_busy[i] = busy;
    end

    assign bus.rs_data = rs_data;
    assign bus.rs_busy = rs_busy;
    assign bus.ready   = ready_q;

endmodule
